// File: rtl/ex_alu_pipe.sv
// ---------------------------------------------------------------------------
// ex_alu_pipe -- execute-stage ALU with two-level operand forwarding and an
// iterative shift-add multiplier. Sits between ID/EX and EX/MEM.
//
// Parameters:
//   WIDTH : datapath width (>=4, power of two)
//   SHW   : shift-amount bits taken from operand B
//
// Ports:
//   Clk, Reset           : rising-edge clock, asynchronous active-high reset
//   In_Valid, ALU_Op     : ID/EX instruction valid and operation select
//   ALUSrc, Imm_Data     : select immediate as operand B
//   Read_Data1/2         : register-file operands
//   Fwd_A/Fwd_B          : 00/11 regfile, 01 EX_MEM_Data, 10 MEM_WB_Data
//   EX_MEM_Data          : forwarded EX/MEM result
//   MEM_WB_Data          : forwarded MEM/WB write data
//   Stall                : freeze all state
//   Flush                : kill current/pending result (wins over Stall)
//   Result, Out_Valid    : registered result and its valid strobe
//   Busy                 : multiply in progress, upstream must hold
//   Zero/Carry/Overflow  : registered flags, present only with ALU_FLAGS_EN
//
// Optional feature macro: ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module ex_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    input  logic [3:0]       ALU_Op,
    input  logic             ALUSrc,
    input  logic [WIDTH-1:0] Read_Data1,
    input  logic [WIDTH-1:0] Read_Data2,
    input  logic [WIDTH-1:0] Imm_Data,
    input  logic [1:0]       Fwd_A,
    input  logic [1:0]       Fwd_B,
    input  logic [WIDTH-1:0] EX_MEM_Data,
    input  logic [WIDTH-1:0] MEM_WB_Data,
    input  logic             Stall,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result,
    output logic             Out_Valid,
    output logic             Busy
`ifdef ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
`endif
);

    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_LI  = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [WIDTH-1:0]  acc_q;
    logic [CNTW-1:0]   cnt_q;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  alu_d;
    logic [WIDTH-1:0]  acc_d;
    logic              accept;
    logic              mul_done;

    // Single-cycle operations; undefined opcodes produce zero.
    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [SHW-1:0]          sh;
        a_s = $signed(a);
        b_s = $signed(b);
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLL:  alu_f = a << sh;
            OP_SRL:  alu_f = a >> sh;
            OP_SRA:  alu_f = $unsigned(a_s >>> sh);
            OP_LI:   alu_f = b;
            default: alu_f = '0;
        endcase
    endfunction

    always_comb begin
        case (Fwd_A)
            2'b01:   op_a = EX_MEM_Data;
            2'b10:   op_a = MEM_WB_Data;
            default: op_a = Read_Data1;
        endcase
        if (ALUSrc) begin
            op_b = Imm_Data;
        end else begin
            case (Fwd_B)
                2'b01:   op_b = EX_MEM_Data;
                2'b10:   op_b = MEM_WB_Data;
                default: op_b = Read_Data2;
            endcase
        end
    end

    assign alu_d    = alu_f(ALU_Op, op_a, op_b);
    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign accept   = In_Valid & ~Stall & ~Flush & (state_q == S_IDLE);
    assign mul_done = (state_q == S_MUL) & ~Stall & ~Flush & (cnt_q == CNTW'(1));
    assign Result   = result_q;

    // ---- EX -> EX/MEM register boundary, multiplier FSM ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else if (Flush) begin
            state_q   <= S_IDLE;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
        end else if (!Stall) begin
            case (state_q)
                S_IDLE: begin
                    if (In_Valid && ALU_Op == OP_MUL) begin
                        mcand_q   <= op_a;
                        mplier_q  <= op_b;
                        acc_q     <= '0;
                        cnt_q     <= CNTW'(WIDTH);
                        Busy      <= 1'b1;
                        Out_Valid <= 1'b0;
                        state_q   <= S_MUL;
                    end else if (In_Valid) begin
                        result_q  <= alu_d;
                        Out_Valid <= 1'b1;
                    end else begin
                        Out_Valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        result_q  <= acc_d;
                        Out_Valid <= 1'b1;
                        Busy      <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic carry_d;
    logic ovf_d;

    // Carry on ADD is detected by wrap-around (sum below an addend);
    // overflow uses the operand signs against the result sign.
    always_comb begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (ALU_Op)
            OP_ADD: begin
                carry_d = (alu_d < op_a);
                ovf_d   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (alu_d[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                carry_d = (op_a < op_b);
                ovf_d   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                          (alu_d[WIDTH-1] != op_a[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // ---- flag register, loads in lock-step with Result ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept && ALU_Op != OP_MUL) begin
            Zero     <= (alu_d == '0);
            Carry    <= carry_d;
            Overflow <= ovf_d;
        end else if (mul_done) begin
            Zero     <= (acc_d == '0);
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu_pipe.sv
module tb_ex_alu_pipe;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       In_Valid = 1'b0;
    logic [3:0] ALU_Op = 4'd0;
    logic       ALUSrc = 1'b0;
    logic [7:0] Read_Data1 = 8'd0, Read_Data2 = 8'd0, Imm_Data = 8'd0;
    logic [1:0] Fwd_A = 2'd0, Fwd_B = 2'd0;
    logic [7:0] EX_MEM_Data = 8'd0, MEM_WB_Data = 8'd0;
    logic       Stall = 1'b0, Flush = 1'b0;
    logic [7:0] Result;
    logic       Out_Valid, Busy;
`ifdef ALU_FLAGS_EN
    logic       Zero, Carry, Overflow;
`endif

    int checks = 0;
    int failures = 0;

    ex_alu_pipe #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .ALU_Op(ALU_Op),
        .ALUSrc(ALUSrc), .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
        .Imm_Data(Imm_Data), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B),
        .EX_MEM_Data(EX_MEM_Data), .MEM_WB_Data(MEM_WB_Data),
        .Stall(Stall), .Flush(Flush), .Result(Result),
        .Out_Valid(Out_Valid), .Busy(Busy)
`ifdef ALU_FLAGS_EN
        , .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
`endif
    );

    always #5 Clk = ~Clk;

    // Reference behaviour in plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
        int sa, sb, sh;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        case (op)
            0:  return 8'((a + b) % 256);
            1:  return 8'((a - b + 256) % 256);
            2:  return 8'(a & b);
            3:  return 8'(a | b);
            4:  return 8'(a ^ b);
            5:  return (sa < sb) ? 8'd1 : 8'd0;
            6:  return 8'((a << sh) % 256);
            7:  return 8'(a >> sh);
            8:  return 8'((sa >>> sh) & 255);
            9:  return 8'(b);
            10: return 8'((a * b) % 256);
            default: return 8'd0;
        endcase
    endfunction

    function automatic int fwd_sel(input int sel, input int rf, input int exm, input int mwb);
        if (sel == 1) return exm;
        if (sel == 2) return mwb;
        return rf;
    endfunction

    task automatic drive(input logic [3:0] op, input logic src, input logic [7:0] rd1,
                         input logic [7:0] rd2, input logic [7:0] imm);
        ALU_Op = op; ALUSrc = src; Read_Data1 = rd1; Read_Data2 = rd2; Imm_Data = imm;
        Fwd_A = 2'd0; Fwd_B = 2'd0; In_Valid = 1'b1;
    endtask

    task automatic idle();
        In_Valid = 1'b0;
    endtask

    task automatic mul_wait(output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (Busy) bcnt++;
        end while (!Out_Valid && cyc < 40);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        checks++; if (Result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", Result); end
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Out_Valid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        Reset = 1'b0;
    endtask

    task automatic test_li();
        @(negedge Clk);
        drive(4'd9, 1'b1, 8'h00, 8'h00, 8'h2A);
        @(negedge Clk);
        checks++; if (Result !== 8'h2A) begin failures++; $display("FAIL li_result got=%h exp=2a", Result); end
        checks++; if (Out_Valid !== 1'b1) begin failures++; $display("FAIL li_valid got=%b exp=1", Out_Valid); end
        idle();
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL li_bubble_valid got=%b exp=0", Out_Valid); end
        checks++; if (Result !== 8'h2A) begin failures++; $display("FAIL li_bubble_hold got=%h exp=2a", Result); end
    endtask

    task automatic test_forward();
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'h13; exp_tab[1] = 8'h23; exp_tab[2] = 8'h08; exp_tab[3] = 8'h08;
        for (int i = 0; i < 4; i++) begin
            drive(4'd0, 1'b1, 8'h05, 8'h00, 8'h03);
            EX_MEM_Data = 8'h10; MEM_WB_Data = 8'h20;
            Fwd_A = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : (i == 2) ? 2'b00 : 2'b11;
            @(negedge Clk);
            checks++;
            if (Result !== exp_tab[i] || Out_Valid !== 1'b1) begin
                failures++; $display("FAIL fwd_case%0d got=%h/%b exp=%h/1", i, Result, Out_Valid, exp_tab[i]);
            end
        end
        idle();
        @(negedge Clk);
    endtask

    task automatic test_directed();
        drive(4'd1, 1'b0, 8'h00, 8'h01, 8'h00);
        @(negedge Clk);
        checks++; if (Result !== 8'hFF) begin failures++; $display("FAIL sub_wrap got=%h exp=ff", Result); end
`ifdef ALU_FLAGS_EN
        checks++; if ({Zero, Carry, Overflow} !== 3'b010) begin failures++; $display("FAIL sub_flags got=%b exp=010", {Zero, Carry, Overflow}); end
`endif
        drive(4'd0, 1'b0, 8'h7F, 8'h01, 8'h00);
        @(negedge Clk);
        checks++; if (Result !== 8'h80) begin failures++; $display("FAIL add_ovf got=%h exp=80", Result); end
`ifdef ALU_FLAGS_EN
        checks++; if ({Zero, Carry, Overflow} !== 3'b001) begin failures++; $display("FAIL add_flags got=%b exp=001", {Zero, Carry, Overflow}); end
`endif
        drive(4'd5, 1'b0, 8'h80, 8'h01, 8'h00);
        @(negedge Clk);
        checks++; if (Result !== 8'h01) begin failures++; $display("FAIL slt_signed got=%h exp=01", Result); end
        drive(4'd8, 1'b1, 8'h80, 8'h00, 8'h03);
        @(negedge Clk);
        checks++; if (Result !== 8'hF0) begin failures++; $display("FAIL sra got=%h exp=f0", Result); end
        idle();
        @(negedge Clk);
    endtask

    task automatic test_random_single();
        logic [7:0] last;
        last = Result;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(negedge Clk);
                checks++;
                if (Out_Valid !== 1'b0 || Result !== last) begin
                    failures++; $display("FAIL rand_bubble n=%0d got=%h/%b exp=%h/0", n, Result, Out_Valid, last);
                end
            end else begin
                int op, a, b;
                op = $urandom_range(0, 14);
                if (op >= 10) op++;
                ALU_Op = 4'(op);
                ALUSrc = 1'($urandom_range(0, 1));
                Read_Data1 = 8'($urandom); Read_Data2 = 8'($urandom);
                Imm_Data = 8'($urandom); EX_MEM_Data = 8'($urandom); MEM_WB_Data = 8'($urandom);
                Fwd_A = 2'($urandom_range(0, 3)); Fwd_B = 2'($urandom_range(0, 3));
                In_Valid = 1'b1;
                a = fwd_sel(int'(Fwd_A), int'(Read_Data1), int'(EX_MEM_Data), int'(MEM_WB_Data));
                b = ALUSrc ? int'(Imm_Data) : fwd_sel(int'(Fwd_B), int'(Read_Data2), int'(EX_MEM_Data), int'(MEM_WB_Data));
                last = ref_alu(op, a, b);
                @(negedge Clk);
                checks++;
                if (Result !== last || Out_Valid !== 1'b1) begin
                    failures++; $display("FAIL rand_op n=%0d op=%0d a=%h b=%h got=%h/%b exp=%h/1", n, op, a, b, Result, Out_Valid, last);
                end
            end
        end
        idle();
        @(negedge Clk);
    endtask

    task automatic test_mul();
        int cyc, bcnt;
        logic [7:0] a, b, e;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin a = 8'h0D; b = 8'h0B; end
            else if (i == 1) begin a = 8'hFF; b = 8'hFF; end
            else begin a = 8'($urandom); b = 8'($urandom); end
            e = ref_alu(10, int'(a), int'(b));
            drive(4'd10, 1'b0, a, b, 8'h00);
            mul_wait(cyc, bcnt);
            idle();
            checks++;
            if (Result !== e || Out_Valid !== 1'b1 || Busy !== 1'b0) begin
                failures++; $display("FAIL mul_result %h*%h got=%h/%b/%b exp=%h/1/0", a, b, Result, Out_Valid, Busy, e);
            end
            checks++;
            if (cyc != 9 || bcnt != 8) begin
                failures++; $display("FAIL mul_timing got cyc=%0d busy=%0d exp cyc=9 busy=8", cyc, bcnt);
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        drive(4'd10, 1'b0, 8'h06, 8'h07, 8'h00);
        @(negedge Clk);
        drive(4'd0, 1'b0, 8'h11, 8'h22, 8'h00);
        mul_wait(cyc, bcnt);
        checks++;
        if (Result !== 8'd42 || cyc != 8) begin
            failures++; $display("FAIL busy_ignore_mul got=%h cyc=%0d exp=2a cyc=8", Result, cyc);
        end
        @(negedge Clk);
        idle();
        checks++;
        if (Result !== 8'h33 || Out_Valid !== 1'b1) begin
            failures++; $display("FAIL busy_then_add got=%h/%b exp=33/1", Result, Out_Valid);
        end
        @(negedge Clk);
    endtask

    task automatic test_stall();
        int cyc;
        drive(4'd10, 1'b0, 8'h0D, 8'h0B, 8'h00);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) idle();
            if (cyc == 3) Stall = 1'b1;
            if (cyc == 6) Stall = 1'b0;
        end while (!Out_Valid && cyc < 40);
        checks++;
        if (cyc != 12 || Result !== 8'h8F) begin
            failures++; $display("FAIL stall_mul got cyc=%0d res=%h exp cyc=12 res=8f", cyc, Result);
        end
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (Out_Valid !== 1'b1 || Result !== 8'h8F) begin
                failures++; $display("FAIL stall_hold k=%0d got=%h/%b exp=8f/1", k, Result, Out_Valid);
            end
        end
        Stall = 1'b0;
        @(negedge Clk);
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", Out_Valid); end
    endtask

    task automatic test_flush();
        drive(4'd9, 1'b1, 8'h00, 8'h00, 8'h5A);
        @(negedge Clk);
        drive(4'd10, 1'b0, 8'h03, 8'h05, 8'h00);
        repeat (3) begin
            @(negedge Clk);
            idle();
        end
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0 || Result !== 8'h5A) begin
            failures++; $display("FAIL flush_mul got=%b/%b/%h exp=0/0/5a", Busy, Out_Valid, Result);
        end
        drive(4'd0, 1'b1, 8'h40, 8'h00, 8'h02);
        @(negedge Clk);
        checks++;
        if (Result !== 8'h42 || Out_Valid !== 1'b1) begin
            failures++; $display("FAIL flush_next_add got=%h/%b exp=42/1", Result, Out_Valid);
        end
        drive(4'd0, 1'b1, 8'h01, 8'h00, 8'h01);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        idle();
        checks++;
        if (Result !== 8'h42 || Out_Valid !== 1'b0) begin
            failures++; $display("FAIL flush_with_valid got=%h/%b exp=42/0", Result, Out_Valid);
        end
    endtask

    task automatic test_async_reset();
        drive(4'd9, 1'b1, 8'h00, 8'h00, 8'h77);
        @(negedge Clk);
        drive(4'd10, 1'b0, 8'h09, 8'h09, 8'h00);
        repeat (3) begin
            @(negedge Clk);
            idle();
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (Result !== 8'h00 || Out_Valid !== 1'b0 || Busy !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b exp=00/0/0", Result, Out_Valid, Busy);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle got=%b/%b exp=0/0", Busy, Out_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_forward();
        test_directed();
        test_random_single();
        test_mul();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
